// File: rtl/bl_pkg.sv
// Shared types for the FT60X receive front end: FSM encoding and bus byte width.
package bl_pkg;

   localparam int unsigned FT_BYTE_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_READ = 2'd2
   } state_e;

endpackage

// File: rtl/ft60x_rx_stream_if.sv
// FT60X read-side pins plus the downstream valid/ready byte stream.
// master = front-end view, slave = FT60X device / shifter side.
interface ft60x_rx_stream_if
   import bl_pkg::*;
#(
   parameter int unsigned DATA_W = FT_BYTE_W
);
   logic              ftdi_rxf_n;
   logic [DATA_W-1:0] ftdi_data;
   logic              ftdi_rd_n;
   logic [DATA_W-1:0] m_data;
   logic              m_valid;
   logic              m_ready;

   modport master (
      input  ftdi_rxf_n, ftdi_data, m_ready,
      output ftdi_rd_n, m_data, m_valid
   );

   modport slave (
      output ftdi_rxf_n, ftdi_data, m_ready,
      input  ftdi_rd_n, m_data, m_valid
   );
endinterface

// File: rtl/ft60x_rx_fifo.sv
// Synchronous first-word-fall-through FIFO; head word is visible on rdata_o while
// non-empty. Push when full and pop when empty are ignored; flush empties it.
module ft60x_rx_fifo #(
   parameter int unsigned AW = 4,
   parameter int unsigned DW = 8
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          flush_i,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic [DW-1:0] wdata_i,
   output logic [DW-1:0] rdata_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [AW:0]   level_o
);
   localparam int unsigned LW    = AW + 1;
   localparam int unsigned DEPTH = 1 << AW;

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [LW-1:0] level_q;
   logic          do_push_c, do_pop_c;

   assign full_o    = (level_q == LW'(DEPTH));
   assign empty_o   = (level_q == '0);
   assign do_push_c = push_i && !full_o;
   assign do_pop_c  = pop_i && !empty_o;
   assign rdata_o   = mem_q[rd_ptr_q];
   assign level_o   = level_q;

   always_ff @(posedge clk_i) begin
      if (do_push_c) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   // Pointers wrap naturally at 2**AW
   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (do_push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
         level_q <= level_q + LW'(do_push_c) - LW'(do_pop_c);
      end
   end

endmodule

// File: rtl/ft60x_rx_stream.sv
// FT60X 245-FIFO read front end: strobes bytes off the FT60X bus into a FWFT FIFO
// and serves them as a valid/ready stream. Optional FT60X_RX_CHECKSUM_EN adds rx_checksum_o.
module ft60x_rx_stream
   import bl_pkg::*;
#(
   parameter int unsigned FIFO_AW = 4,
   parameter int unsigned DATA_W  = FT_BYTE_W
) (
   input  logic                 ftdi_clk_i,
   input  logic                 rst_i,
   input  logic                 enable_i,
   ft60x_rx_stream_if.master    bus,
   output logic [FIFO_AW:0]     fifo_level_o,
`ifdef FT60X_RX_CHECKSUM_EN
   output logic [15:0]          rx_checksum_o,
`endif
   output logic [31:0]          byte_count_o
);
   localparam int unsigned LW    = FIFO_AW + 1;
   localparam int unsigned DEPTH = 1 << FIFO_AW;

   state_e            state_q, state_d;
   logic              rd_n_q, rd_n_d;
   logic              enable_q;
   logic              en_rise_c, push_c, pop_c, room_c;
   logic              full, empty;
   logic [LW-1:0]     level, lvl_nxt_c;
   logic [DATA_W-1:0] rdata;
   logic [31:0]       count_q;

   assign en_rise_c = enable_i && !enable_q;
   assign push_c    = !rd_n_q && !bus.ftdi_rxf_n && enable_i && !full;
   assign pop_c     = bus.m_valid && bus.m_ready;
   // Strobe may stay low only if this edge leaves at least one free slot
   assign lvl_nxt_c = level + LW'(push_c) - LW'(pop_c);
   assign room_c    = (lvl_nxt_c != LW'(DEPTH));

   ft60x_rx_fifo #(.AW(FIFO_AW), .DW(DATA_W)) u_fifo (
      .clk_i   (ftdi_clk_i),
      .rst_i   (rst_i),
      .flush_i (!enable_i),
      .push_i  (push_c),
      .pop_i   (pop_c),
      .wdata_i (bus.ftdi_data),
      .rdata_o (rdata),
      .full_o  (full),
      .empty_o (empty),
      .level_o (level)
   );

   assign bus.m_data    = rdata;
   assign bus.m_valid   = !empty;
   assign bus.ftdi_rd_n = rd_n_q;
   assign fifo_level_o  = level;
   assign byte_count_o  = count_q;

   always_ff @(posedge ftdi_clk_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         rd_n_q   <= 1'b1;
         enable_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         rd_n_q   <= rd_n_d;
         enable_q <= enable_i;
      end
   end

   // rd_n is low exactly while the registered state is READ
   always_comb begin
      state_d = state_q;
      rd_n_d  = 1'b1;
      case (state_q)
         ST_IDLE: state_d = ST_ARM;
         ST_ARM:  if (!bus.ftdi_rxf_n && room_c) state_d = ST_READ;
         ST_READ: if (bus.ftdi_rxf_n || !room_c) state_d = ST_ARM;
         default: state_d = ST_IDLE;
      endcase
      if (!enable_i) state_d = ST_IDLE;
      rd_n_d = (state_d != ST_READ);
   end

   always_ff @(posedge ftdi_clk_i) begin
      if (rst_i || en_rise_c) begin
         count_q <= '0;
      end else if (push_c && (count_q != 32'hFFFF_FFFF)) begin
         count_q <= count_q + 32'd1;
      end
   end

`ifdef FT60X_RX_CHECKSUM_EN
   logic [15:0] cks_q;

   always_ff @(posedge ftdi_clk_i) begin
      if (rst_i || en_rise_c) begin
         cks_q <= '0;
      end else if (pop_c) begin
         cks_q <= cks_q + 16'(rdata);
      end
   end

   assign rx_checksum_o = cks_q;
`endif

endmodule

// File: tb/tb_ft60x_rx_stream.sv
// Directed bench for ft60x_rx_stream: vector table for the basic burst, FT60X device
// model plus in-order stream scoreboard for full, toggle, enable-drop and checksum cases.
module tb_ft60x_rx_stream;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [4:0]  level;
   logic [31:0] count;
   logic [15:0] cks;

   always #5 clk = ~clk;

   ft60x_rx_stream_if #(.DATA_W(8)) bus ();

   ft60x_rx_stream #(.FIFO_AW(4), .DATA_W(8)) dut (
      .ftdi_clk_i    (clk),
      .rst_i         (rst),
      .enable_i      (en),
      .bus           (bus),
      .fifo_level_o  (level),
`ifdef FT60X_RX_CHECKSUM_EN
      .rx_checksum_o (cks),
`endif
      .byte_count_o  (count)
   );

   int          n_vec = 0;
   int          n_bad = 0;
   logic [7:0]  dev_byte = 8'h00;
   logic [7:0]  exp_byte = 8'h00;
   bit          dev_ff = 1'b0;
   bit          chk_stream = 1'b0;
   bit          track = 1'b0;
   int          lvl_m = 0;
   logic [31:0] cnt_m = 32'd0;
   logic        prev_en = 1'b0;
   int          advs = 0;

   typedef struct {
      logic       en;
      logic       rxf_n;
      logic [7:0] data;
      logic       rdy;
      logic       e_rd_n;
      logic       e_valid;
      logic [7:0] e_data;
      logic [4:0] e_level;
      logic [31:0] e_cnt;
   } vec_t;

   vec_t tbl [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock: FT60X model advances its byte on every strobed edge with data available
   task automatic tick();
      bit adv, push, pop;
      adv  = (bus.ftdi_rd_n == 1'b0) && (bus.ftdi_rxf_n == 1'b0);
      push = adv && en && !rst;
      pop  = bus.m_valid && bus.m_ready;
      if (pop && chk_stream) begin
         check("stream_order", 32'(bus.m_data), 32'(exp_byte));
         exp_byte = exp_byte + 8'd1;
      end
      @(posedge clk);
      #1;
      if (rst || !en) lvl_m = 0;
      else            lvl_m = lvl_m + int'(push) - int'(pop);
      if (rst || (en && !prev_en)) cnt_m = 32'd0;
      else if (push)               cnt_m = cnt_m + 32'd1;
      prev_en = rst ? 1'b0 : en;
      if (adv) begin
         advs++;
         if (!dev_ff) dev_byte = dev_byte + 8'd1;
      end
      bus.ftdi_data = dev_ff ? 8'hFF : dev_byte;
      if (track) begin
         check("level_track", 32'(level), 32'(lvl_m));
         check("count_track", count, cnt_m);
      end
   endtask

   initial begin
      tbl[0] = '{1'b1, 1'b0, 8'h01, 1'b1, 1'b1, 1'b0, 8'h00, 5'd0, 32'd0};
      tbl[1] = '{1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 32'd0};
      tbl[2] = '{1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 1'b1, 8'h01, 5'd1, 32'd1};
      tbl[3] = '{1'b1, 1'b0, 8'h02, 1'b1, 1'b0, 1'b1, 8'h02, 5'd1, 32'd2};
      tbl[4] = '{1'b1, 1'b0, 8'h03, 1'b1, 1'b0, 1'b1, 8'h03, 5'd1, 32'd3};
      tbl[5] = '{1'b1, 1'b0, 8'h04, 1'b1, 1'b0, 1'b1, 8'h04, 5'd1, 32'd4};
      tbl[6] = '{1'b1, 1'b0, 8'h05, 1'b1, 1'b0, 1'b1, 8'h05, 5'd1, 32'd5};
      tbl[7] = '{1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 5'd0, 32'd5};

      // Reset held with data available: strobe must stay high, FIFO empty
      rst = 1'b1;
      en  = 1'b1;
      bus.ftdi_rxf_n = 1'b0;
      bus.ftdi_data  = 8'hAA;
      bus.m_ready    = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("rst_rd_n",  32'(bus.ftdi_rd_n), 32'd1);
         check("rst_valid", 32'(bus.m_valid),   32'd0);
         check("rst_level", 32'(level),         32'd0);
         check("rst_count", count,              32'd0);
`ifdef FT60X_RX_CHECKSUM_EN
         check("rst_cks",   32'(cks),           32'd0);
`endif
      end
      rst = 1'b0;

      // Five-byte burst with continuous downstream acceptance
      for (int i = 0; i < 8; i++) begin
         en             = tbl[i].en;
         bus.ftdi_rxf_n = tbl[i].rxf_n;
         bus.ftdi_data  = tbl[i].data;
         bus.m_ready    = tbl[i].rdy;
         @(posedge clk);
         #1;
         check("vec_rd_n",  32'(bus.ftdi_rd_n), 32'(tbl[i].e_rd_n));
         check("vec_valid", 32'(bus.m_valid),   32'(tbl[i].e_valid));
         if (tbl[i].e_valid) check("vec_data", 32'(bus.m_data), 32'(tbl[i].e_data));
         check("vec_level", 32'(level), 32'(tbl[i].e_level));
         check("vec_count", count, tbl[i].e_cnt);
      end

      // Fill to full with downstream stalled, then drain while reads resume
      lvl_m = 0; cnt_m = 32'd5; prev_en = 1'b1; track = 1'b1;
      dev_byte = 8'h10; exp_byte = 8'h10; chk_stream = 1'b1; advs = 0;
      bus.ftdi_data  = dev_byte;
      bus.ftdi_rxf_n = 1'b0;
      bus.m_ready    = 1'b0;
      repeat (24) tick();
      check("full_level",  32'(level),         32'd16);
      check("full_rd_n",   32'(bus.ftdi_rd_n), 32'd1);
      check("full_pushes", 32'(advs),          32'd16);
      check("full_head",   32'(bus.m_data),    32'h10);
      check("full_count",  count,              32'd21);
      bus.m_ready = 1'b1;
      repeat (24) tick();
      check("resume_rd_n", 32'(bus.ftdi_rd_n), 32'd0);

      // rxf_n toggling every cycle, then drain completely
      for (int i = 0; i < 40; i++) begin
         bus.ftdi_rxf_n = (i % 2) != 0;
         tick();
      end
      bus.ftdi_rxf_n = 1'b1;
      repeat (24) tick();
      check("toggle_empty",   32'(bus.m_valid), 32'd0);
      check("toggle_no_loss", 32'(exp_byte),    32'(dev_byte));

      // Drop enable mid-burst at level 7
      bus.m_ready    = 1'b0;
      bus.ftdi_rxf_n = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (level == 5'd7) break;
      end
      check("pre_drop_level", 32'(level),         32'd7);
      check("pre_drop_rd_n",  32'(bus.ftdi_rd_n), 32'd0);
      en = 1'b0;
      tick();
      check("drop_rd_n",  32'(bus.ftdi_rd_n), 32'd1);
      check("drop_level", 32'(level),         32'd0);
      check("drop_valid", 32'(bus.m_valid),   32'd0);
      tick();
      en = 1'b1;
      tick();
      check("rise_count", count,              32'd0);
      check("rise_rd_n",  32'(bus.ftdi_rd_n), 32'd1);
      exp_byte = dev_byte;
      tick();
      check("rearm_rd_n", 32'(bus.ftdi_rd_n), 32'd0);
      tick();
      check("first_after_rise", count, 32'd1);
      bus.ftdi_rxf_n = 1'b1;
      bus.m_ready    = 1'b1;
      repeat (8) tick();
      check("rise_no_loss", 32'(exp_byte), 32'(dev_byte));

`ifdef FT60X_RX_CHECKSUM_EN
      // 300 bytes of 0xFF through the stream
      en = 1'b0;
      tick();
      en = 1'b1;
      tick();
      check("cks_clear", 32'(cks), 32'd0);
      chk_stream = 1'b0;
      dev_ff = 1'b1;
      bus.ftdi_data = 8'hFF;
      advs = 0;
      for (int i = 0; i < 2000; i++) begin
         bus.ftdi_rxf_n = (advs >= 300);
         if (advs >= 300 && !bus.m_valid && bus.ftdi_rd_n) break;
         tick();
      end
      check("cks_pushes", 32'(advs), 32'd300);
      check("cks_value",  32'(cks),  32'h2AD4);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
